chip_prog_receiver: RTL and testbench
=====================================

// Module: chip_prog_receiver
// PURPOSE
//  Chip-side programming deserializer. Consumes the serial programming stream (sclk/sdin) from the FPGA
//  programming master and captures the amplifier gain codes into chip registers. When a complete
//  frame is captured it raises ready back to the FPGA, and it flags frames that stall mid-stream.
//  Sits directly downstream of the FPGA programming master; its outputs drive the A1/A2 gain controls.
// PARAMETERS
//  W_A1       2    width of amplifier-1 gain code (first bits of the frame)
//  W_A2       3    width of amplifier-2 gain code (last bits of the frame)
//  TIMEOUT    64   i_mainclk cycles without any sclk edge while in sSHIFT before the frame is aborted
//  GAINA1_RST 0    reset value of o_gainA1
//  GAINA2_RST 0    reset value of o_gainA2
// PORTS
//  i_mainclk    in   1     main clock; every flop is clocked on its rising edge
//  i_reset      in   1     synchronous, active-high reset
//  i_sclk       in   1     serial clock from the FPGA, asynchronous to i_mainclk, idles high
//  i_sdin       in   1     serial data from the FPGA; changes on sclk falling edge, LSB first
//  o_gainA1     out  W_A1  captured amplifier-1 gain code
//  o_gainA2     out  W_A2  captured amplifier-2 gain code
//  o_ready      out  1     high = frame captured and gains valid; goes back to the FPGA
//  o_frame_err  out  1     high = last frame aborted by timeout
// BEHAVIOUR
//  - Reset (i_reset=1 at posedge): state=sIDLE, o_gainA1=GAINA1_RST, o_gainA2=GAINA2_RST, o_ready=0,
//    o_frame_err=0, shift reg=0, bit counter=0, timeout counter=0, synchronizers preset to 1 (idle).
//    Reset has priority over every other event, including one that arrives mid-frame.
//  - i_sclk and i_sdin each pass through a 2-flop synchronizer, followed by one edge-history flop on sclk.
//    rise = sync_sclk & ~prev_sclk; fall = ~sync_sclk & prev_sclk.
//  - i_sclk high and low phases must each be >= 3 i_mainclk cycles.
//  - Capture: on a rise in sSHIFT, sampled sdin shifts in at the MSB of the NB=W_A1+W_A2 bit shift reg
//    (right shift, so the first bit ends at bit 0). The bit counter then increments.
//    Bit order on the wire: gainA1[0..W_A1-1], then gainA2[0..W_A2-1].
//  - A bit is in the shift reg 3 cycles after the i_sclk rising edge (2 sync + 1 edge).
//  - States:
//    sIDLE : waits for sclk fall -> sSHIFT (counters cleared). No other event changes state.
//    sSHIFT: on each rise, shift; when the rise is bit NB -> sDONE.
//            Timeout counter clears on any rise/fall and otherwise increments.
//            When it reaches TIMEOUT-1 -> sERROR.
//    sDONE : entry cycle loads o_gainA1=sr[W_A1-1:0] and o_gainA2=sr[NB-1:W_A1], sets o_ready=1.
//            Sticky until reset; later sclk/sdin activity is ignored (gains frozen).
//    sERROR: o_frame_err=1, shift reg and bit counter cleared, gains keep prior values, o_ready=0.
//            Next sclk fall -> sSHIFT (new frame) with o_frame_err cleared in the same cycle.
//  - o_ready rises 1 cycle after the final rise is detected, i.e. 4 i_mainclk cycles after the final
//    i_sclk rising edge. o_gainA1/o_gainA2 change only in that same cycle.
//  - Counter widths: bit counter $clog2(NB+1); timeout counter $clog2(TIMEOUT), saturating and never wrapping.
//  - A rise and a timeout in the same cycle: the rise wins (the edge counts as activity).
//  - A sclk rise while in sIDLE (no preceding fall) is ignored.
// TESTING
//  1. Frame bits 0,1,1,0,1 at sclk = mainclk/32 -> o_gainA1=2, o_gainA2=5, o_ready=1
//     4 cycles after the 5th sclk rise, o_frame_err=0.
//  2. After test 1, 10 more sclk toggles with sdin=1 -> gains stay 2/5, o_ready stays 1.
//  3. 3 bits sent, then sclk held high 64 cycles -> o_frame_err=1, o_ready=0, gains=0/0.
//     Then full frame 1,1,1,1,1 -> o_gainA1=3, o_gainA2=7, o_ready=1, o_frame_err=0.
//  4. i_reset=1 for 1 cycle after the 4th bit of a frame -> all outputs reset next cycle.
//     Then a full frame 0,0,1,0,0 -> o_gainA1=0, o_gainA2=1, o_ready=1.
//  5. Minimum-timing frame (sclk phases of exactly 3 cycles) with pattern 1,0,0,1,1 -> o_gainA1=1, o_gainA2=6.
//  6. Timeout counter at 62 and a rise in the same cycle -> no error; the bit is captured.

Source files
------------

// File: rtl/chip_prog_receiver.sv
// -----------------------------------------------------------------------------
// chip_prog_receiver
//
// Chip-side deserializer for the FPGA programming stream. It samples sclk and
// sdin with i_mainclk, shifts in one frame of NB = W_A1 + W_A2 bits (LSB first:
// gainA1 then gainA2), and latches the amplifier gain codes once the frame is
// complete. A frame that stalls mid-stream is aborted and flagged.
//
// Ports
//   i_mainclk   in   1     main clock, all flops on its rising edge
//   i_reset     in   1     synchronous active-high reset
//   i_sclk      in   1     serial clock from the FPGA (async, idles high)
//   i_sdin      in   1     serial data, changes on sclk fall, LSB first
//   o_gainA1    out  W_A1  captured amplifier-1 gain code
//   o_gainA2    out  W_A2  captured amplifier-2 gain code
//   o_ready     out  1     frame captured, gains valid (sticky until reset)
//   o_frame_err out  1     last frame aborted by timeout
// -----------------------------------------------------------------------------
module chip_prog_receiver #(
  parameter int              W_A1       = 2,
  parameter int              W_A2       = 3,
  parameter int              TIMEOUT    = 64,
  parameter logic [W_A1-1:0] GAINA1_RST = '0,
  parameter logic [W_A2-1:0] GAINA2_RST = '0
) (
  input  logic            i_mainclk,
  input  logic            i_reset,
  input  logic            i_sclk,
  input  logic            i_sdin,
  output logic [W_A1-1:0] o_gainA1,
  output logic [W_A2-1:0] o_gainA2,
  output logic            o_ready,
  output logic            o_frame_err
);

  localparam int NB  = W_A1 + W_A2;
  localparam int BCW = $clog2(NB + 1);
  localparam int TCW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    sIDLE  = 2'd0,
    sSHIFT = 2'd1,
    sDONE  = 2'd2,
    sERROR = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sclk_s1;
  logic            r_sclk_s2;
  logic            r_sclk_prev;
  logic            r_sdin_s1;
  logic            r_sdin_s2;
  logic [NB-1:0]   r_sr;
  logic [BCW-1:0]  r_bitcnt;
  logic [TCW-1:0]  r_to;
  logic [W_A1-1:0] r_gainA1;
  logic [W_A2-1:0] r_gainA2;
  logic            r_ready;
  logic            r_frame_err;

  logic w_rise;
  logic w_fall;

  // Edges are taken from the synchronized sclk against one extra history flop,
  // so sdin_s2 is aligned with the rise that samples it.
  assign w_rise = r_sclk_s2 & ~r_sclk_prev;
  assign w_fall = ~r_sclk_s2 & r_sclk_prev;

  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      r_state     <= sIDLE;
      r_sclk_s1   <= 1'b1;
      r_sclk_s2   <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_sdin_s1   <= 1'b1;
      r_sdin_s2   <= 1'b1;
      r_sr        <= '0;
      r_bitcnt    <= '0;
      r_to        <= '0;
      r_gainA1    <= GAINA1_RST;
      r_gainA2    <= GAINA2_RST;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_s1   <= i_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_sdin_s1   <= i_sdin;
      r_sdin_s2   <= r_sdin_s1;

      case (r_state)
        sIDLE: begin
          // A rise without a preceding fall is not a frame start.
          if (w_fall) begin
            r_state  <= sSHIFT;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_to     <= '0;
          end
        end

        sSHIFT: begin
          // The rise is checked first so an edge in the timeout cycle still
          // counts as activity.
          if (w_rise) begin
            r_sr     <= {r_sdin_s2, r_sr[NB-1:1]};
            r_bitcnt <= r_bitcnt + BCW'(1);
            r_to     <= '0;
            if (r_bitcnt == BCW'(NB - 1)) begin
              r_state <= sDONE;
            end
          end else if (w_fall) begin
            r_to <= '0;
          end else if (r_to == TCW'(TIMEOUT - 2)) begin
            // Counter reaches TIMEOUT-1 on this edge; it saturates there.
            r_state     <= sERROR;
            r_to        <= TCW'(TIMEOUT - 1);
            r_frame_err <= 1'b1;
            r_sr        <= '0;
            r_bitcnt    <= '0;
            r_ready     <= 1'b0;
          end else begin
            r_to <= r_to + TCW'(1);
          end
        end

        sDONE: begin
          // Gains load once on entry; afterwards the block ignores the wire.
          if (!r_ready) begin
            r_gainA1 <= r_sr[W_A1-1:0];
            r_gainA2 <= r_sr[NB-1:W_A1];
            r_ready  <= 1'b1;
          end
        end

        sERROR: begin
          if (w_fall) begin
            r_state     <= sSHIFT;
            r_frame_err <= 1'b0;
            r_sr        <= '0;
            r_bitcnt    <= '0;
            r_to        <= '0;
          end
        end

        default: r_state <= sIDLE;
      endcase
    end
  end

  assign o_gainA1    = r_gainA1;
  assign o_gainA2    = r_gainA2;
  assign o_ready     = r_ready;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_chip_prog_receiver.sv
// -----------------------------------------------------------------------------
// tb_chip_prog_receiver
//
// Directed and randomized frames sent over sclk/sdin. Expected gains are
// computed from the wire bit order (gainA1 bits first, then gainA2, LSB first).
// -----------------------------------------------------------------------------
module tb_chip_prog_receiver;

  localparam int W_A1 = 2;
  localparam int W_A2 = 3;
  localparam int NB   = W_A1 + W_A2;

  logic            clk;
  logic            rst;
  logic            sclk;
  logic            sdin;
  logic [W_A1-1:0] gainA1;
  logic [W_A2-1:0] gainA2;
  logic            ready;
  logic            frame_err;

  int tests;
  int fails;
  int exp_g1;
  int exp_g2;

  chip_prog_receiver #(
    .W_A1      (W_A1),
    .W_A2      (W_A2),
    .TIMEOUT   (64),
    .GAINA1_RST('0),
    .GAINA2_RST('0)
  ) dut (
    .i_mainclk  (clk),
    .i_reset    (rst),
    .i_sclk     (sclk),
    .i_sdin     (sdin),
    .o_gainA1   (gainA1),
    .o_gainA2   (gainA2),
    .o_ready    (ready),
    .o_frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: gain codes assembled from the wire bit sequence.
  task automatic model_frame(input logic [NB-1:0] bits);
    exp_g1 = 0;
    exp_g2 = 0;
    for (int i = 0; i < W_A1; i++) exp_g1 += int'(bits[i]) * (1 << i);
    for (int i = 0; i < W_A2; i++) exp_g2 += int'(bits[W_A1 + i]) * (1 << i);
  endtask

  task automatic send_bit(input logic b, input int lo, input int hi);
    sclk = 1'b0;
    sdin = b;
    tick(lo);
    sclk = 1'b1;
    tick(hi);
  endtask

  // Full frame; the last rise is followed by an exact o_ready latency check.
  // Bit stall_idx (if >= 0) uses stall_lo as its low phase.
  task automatic send_frame(input string tag, input logic [NB-1:0] bits, input int lo,
                            input int hi, input int stall_idx, input int stall_lo);
    for (int i = 0; i < NB; i++) begin
      sclk = 1'b0;
      sdin = bits[i];
      tick((i == stall_idx) ? stall_lo : lo);
      sclk = 1'b1;
      if (i < NB - 1) begin
        tick(hi);
      end else begin
        tick(3);
        check({tag, "_ready_early"}, 32'(ready), 32'd0);
        tick(1);
        check({tag, "_ready"}, 32'(ready), 32'd1);
      end
    end
    model_frame(bits);
    $display("[TB] frame %s bits=%b lo=%0d hi=%0d -> gA1=%0d gA2=%0d rdy=%0d err=%0d",
             tag, bits, lo, hi, gainA1, gainA2, ready, frame_err);
    check({tag, "_gA1"}, 32'(gainA1), 32'(exp_g1));
    check({tag, "_gA2"}, 32'(gainA2), 32'(exp_g2));
    check({tag, "_err"}, 32'(frame_err), 32'd0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sclk = 1'b1;
    sdin = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] fr;
    int lo;
    int hi;
    tests = 0;
    fails = 0;
    rst  = 1'b1;
    sclk = 1'b1;
    sdin = 1'b1;
    tick(3);
    check("rst_gA1", 32'(gainA1), 32'd0);
    check("rst_gA2", 32'(gainA2), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: bits 0,1,1,0,1 at sclk = mainclk/32
    send_frame("t1", 5'b10110, 16, 16, -1, 0);

    // 2: activity after completion is ignored
    for (int i = 0; i < 5; i++) send_bit(1'b1, 8, 8);
    check("t2_gA1", 32'(gainA1), 32'd2);
    check("t2_gA2", 32'(gainA2), 32'd5);
    check("t2_ready", 32'(ready), 32'd1);

    // 3: stall after 3 bits with sclk high, then a full frame
    do_reset();
    send_bit(1'b1, 8, 8);
    send_bit(1'b0, 8, 8);
    sclk = 1'b0;
    sdin = 1'b1;
    tick(8);
    sclk = 1'b1;
    tick(65);
    check("t3_err_before", 32'(frame_err), 32'd0);
    tick(1);
    check("t3_err", 32'(frame_err), 32'd1);
    check("t3_ready", 32'(ready), 32'd0);
    check("t3_gA1", 32'(gainA1), 32'd0);
    check("t3_gA2", 32'(gainA2), 32'd0);
    tick(10);
    send_frame("t3b", 5'b11111, 8, 8, -1, 0);

    // 4: reset mid-frame after the 4th bit
    do_reset();
    send_bit(1'b1, 8, 8);
    send_bit(1'b1, 8, 8);
    send_bit(1'b1, 8, 8);
    send_bit(1'b0, 8, 8);
    rst = 1'b1;
    tick(1);
    check("t4_gA1", 32'(gainA1), 32'd0);
    check("t4_gA2", 32'(gainA2), 32'd0);
    check("t4_ready", 32'(ready), 32'd0);
    check("t4_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick(2);
    send_frame("t4b", 5'b00100, 8, 8, -1, 0);

    // 5: minimum sclk phases
    do_reset();
    send_frame("t5", 5'b11001, 3, 3, -1, 0);

    // 6: low phase of 63 cycles puts the rise in the timeout cycle -> captured
    do_reset();
    send_frame("t6", 5'b01101, 8, 8, 2, 63);

    // 6b: one cycle longer low phase aborts the frame
    do_reset();
    send_bit(1'b1, 8, 8);
    send_bit(1'b0, 8, 8);
    sclk = 1'b0;
    tick(64);
    sclk = 1'b1;
    tick(6);
    check("t6b_err", 32'(frame_err), 32'd1);
    check("t6b_ready", 32'(ready), 32'd0);

    // Randomized frames
    for (int n = 0; n < 8; n++) begin
      do_reset();
      fr = NB'($urandom);
      lo = int'($urandom_range(3, 12));
      hi = int'($urandom_range(3, 12));
      send_frame("rnd", fr, lo, hi, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
